axi_timer_s_axi_regs: RTL

AXI4-Lite slave (responder) register bank for the AXI transaction timer peripheral, sitting behind the S00_AXI port of the IP. It accepts single-beat AXI4-Lite writes and reads from the upstream master and holds NUM_REGS 32-bit software registers. It exposes the registers and per-register write strobes to the timer core. The AW and W channels are captured independently.

---
 rtl/axi_timer_pkg.sv | 38 +++
 rtl/axi_timer_wr_ctrl.sv | 88 ++++++++
 rtl/axi_timer_s_axi_regs.sv | 126 ++++++++++++
 3 files changed

// File: rtl/axi_timer_pkg.sv
// Shared definitions for the AXI transaction timer register interface:
// response codes, address layout, register word type and write-slot states.
package axi_timer_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int ADDR_LSB = 2;

   typedef logic [31:0] reg_word_t;

   typedef enum logic [1:0] {
      WR_IDLE    = 2'd0,
      WR_AW_HELD = 2'd1,
      WR_W_HELD  = 2'd2,
      WR_RESP    = 2'd3
   } wr_state_e;

   // A slot can take a new beat only while it is empty and no response is pending.
   function automatic logic aw_open(wr_state_e s);
      return (s == WR_IDLE) || (s == WR_W_HELD);
   endfunction

   function automatic logic w_open(wr_state_e s);
      return (s == WR_IDLE) || (s == WR_AW_HELD);
   endfunction

   function automatic reg_word_t apply_strb(reg_word_t old_word, reg_word_t new_word,
                                            logic [3:0] strb);
      reg_word_t merged;
      merged = old_word;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/axi_timer_wr_ctrl.sv
// AW/W holding slots, write commit strobe and B-channel response register.
// state is exported so the top can decode AWREADY/WREADY and checkers can bind to it.
module axi_timer_wr_ctrl
   import axi_timer_pkg::*;
#(
   parameter int IDX_W    = 2,
   parameter int NUM_REGS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             aw_valid,
   input  logic [IDX_W-1:0] aw_idx,
   input  logic             w_valid,
   input  logic [31:0]      w_data,
   input  logic [3:0]       w_strb,
   input  logic             b_ready,
   output logic [1:0]       state,
   output logic             b_valid,
   output logic [1:0]       b_resp,
   output logic             commit,
   output logic [IDX_W-1:0] commit_idx,
   output logic [31:0]      commit_data,
   output logic [3:0]       commit_strb
);

   wr_state_e        cur;
   logic             aw_hs;
   logic             w_hs;
   logic             have_aw;
   logic             have_w;
   logic             in_range;
   logic [IDX_W-1:0] aw_idx_q;
   reg_word_t        w_data_q;
   logic [3:0]       w_strb_q;

   // A beat transfers on any edge where VALID && READY; READY never waits on VALID.
   assign aw_hs   = aw_valid && aw_open(cur);
   assign w_hs    = w_valid && w_open(cur);
   assign have_aw = aw_hs || (cur == WR_AW_HELD);
   assign have_w  = w_hs || (cur == WR_W_HELD);
   assign commit  = have_aw && have_w;

   assign commit_idx  = (cur == WR_AW_HELD) ? aw_idx_q : aw_idx;
   assign commit_data = (cur == WR_W_HELD) ? w_data_q : w_data;
   assign commit_strb = (cur == WR_W_HELD) ? w_strb_q : w_strb;
   assign in_range    = int'(commit_idx) < NUM_REGS;

   assign state = cur;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur      <= WR_IDLE;
         b_valid  <= 1'b0;
         b_resp   <= RESP_OKAY;
         aw_idx_q <= '0;
         w_data_q <= '0;
         w_strb_q <= '0;
      end else begin
         if (aw_hs) aw_idx_q <= aw_idx;
         if (w_hs) begin
            w_data_q <= w_data;
            w_strb_q <= w_strb;
         end
         case (cur)
            WR_IDLE, WR_AW_HELD, WR_W_HELD: begin
               if (commit) begin
                  cur     <= WR_RESP;
                  b_valid <= 1'b1;
                  b_resp  <= in_range ? RESP_OKAY : RESP_SLVERR;
               end else if (aw_hs) begin
                  cur <= WR_AW_HELD;
               end else if (w_hs) begin
                  cur <= WR_W_HELD;
               end
            end
            WR_RESP: begin
               // Both slots stay closed until the response drains; no skid.
               if (b_ready) begin
                  cur     <= WR_IDLE;
                  b_valid <= 1'b0;
               end
            end
            default: cur <= WR_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/axi_timer_s_axi_regs.sv
// AXI4-Lite register bank for the transaction timer: NUM_REGS software registers,
// byte-strobed writes, one outstanding read, per-register write pulses to the core.
module axi_timer_s_axi_regs
   import axi_timer_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int NUM_REGS           = 4
) (
   input  logic                            ACLK,
   input  logic                            ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [3:0]                      S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic [NUM_REGS*32-1:0]          reg_out,
   output logic [NUM_REGS-1:0]             reg_wr_pulse
);

   localparam int IDX_W = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

   logic [1:0]       wr_state;
   logic             commit;
   logic [IDX_W-1:0] commit_idx;
   reg_word_t        commit_data;
   logic [3:0]       commit_strb;
   reg_word_t        regs [NUM_REGS];

   logic [IDX_W-1:0] ar_idx;
   logic             ar_hs;
   logic             ar_in_range;
   reg_word_t        rd_word;
   logic             unused_bits;

   assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                          S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

   axi_timer_wr_ctrl #(
      .IDX_W    (IDX_W),
      .NUM_REGS (NUM_REGS)
   ) u_wr_ctrl (
      .clk         (ACLK),
      .rst_n       (ARESETN),
      .aw_valid    (S_AXI_AWVALID),
      .aw_idx      (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]),
      .w_valid     (S_AXI_WVALID),
      .w_data      (S_AXI_WDATA),
      .w_strb      (S_AXI_WSTRB),
      .b_ready     (S_AXI_BREADY),
      .state       (wr_state),
      .b_valid     (S_AXI_BVALID),
      .b_resp      (S_AXI_BRESP),
      .commit      (commit),
      .commit_idx  (commit_idx),
      .commit_data (commit_data),
      .commit_strb (commit_strb)
   );

   assign S_AXI_AWREADY = aw_open(wr_state_e'(wr_state));
   assign S_AXI_WREADY  = w_open(wr_state_e'(wr_state));

   // Out-of-range commits match no register, so they neither write nor pulse.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         reg_wr_pulse <= '0;
      end else begin
         reg_wr_pulse <= '0;
         if (commit) begin
            for (int i = 0; i < NUM_REGS; i++) begin
               if (int'(commit_idx) == i) begin
                  regs[i]         <= apply_strb(regs[i], commit_data, commit_strb);
                  reg_wr_pulse[i] <= 1'b1;
               end
            end
         end
      end
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_out
      assign reg_out[32*gi +: 32] = regs[gi];
   end

   assign ar_idx        = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
   assign ar_hs         = S_AXI_ARVALID && !S_AXI_RVALID;
   assign ar_in_range   = int'(ar_idx) < NUM_REGS;
   assign S_AXI_ARREADY = !S_AXI_RVALID;

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(ar_idx) == i) rd_word = regs[i];
      end
   end

   // rd_word samples the pre-edge array, so a same-edge write to that register reads old data.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         S_AXI_RVALID <= 1'b0;
         S_AXI_RDATA  <= '0;
         S_AXI_RRESP  <= RESP_OKAY;
      end else if (ar_hs) begin
         S_AXI_RVALID <= 1'b1;
         S_AXI_RDATA  <= ar_in_range ? rd_word : '0;
         S_AXI_RRESP  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
         S_AXI_RVALID <= 1'b0;
      end
   end

endmodule
